multdiv_issue_ctrl: RTL and testbench

//  Sequences the multi-cycle multiply/divide unit for the 5-stage pipeline.

---
 rtl/multdiv_issue_ctrl_pkg.sv | 28 ++
 rtl/multdiv_issue_ctrl_if.sv | 34 +++
 rtl/multdiv_issue_ctrl_busy_counter.sv | 27 ++
 rtl/multdiv_issue_ctrl.sv | 110 +++++++++++
 tb/tb_multdiv_issue_ctrl.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/multdiv_issue_ctrl_pkg.sv
// Shared constants and types for the multiply/divide issue controller.
// The optional watchdog is enabled with the MULTDIV_TIMEOUT_EN macro.
package multdiv_ctrl_pkg;

  localparam logic S_IDLE = 1'b0;
  localparam logic S_BUSY = 1'b1;

  localparam logic [4:0] ALU_OP_MUL = 5'b00110;
  localparam logic [4:0] ALU_OP_DIV = 5'b00111;

  localparam int TIMEOUT_CYCLES_DEF = 40;
  localparam int COUNT_W_DEF        = 6;

  typedef struct packed {
    logic pc_we;
    logic fd_we;
    logic dx_we;
    logic xm_bubble;
  } pipe_ctrl_t;

  localparam pipe_ctrl_t PIPE_RUN  = '{pc_we: 1'b1, fd_we: 1'b1, dx_we: 1'b1, xm_bubble: 1'b0};
  localparam pipe_ctrl_t PIPE_HOLD = '{pc_we: 1'b0, fd_we: 1'b0, dx_we: 1'b0, xm_bubble: 1'b1};

  function automatic logic is_multdiv_op(input logic [4:0] op);
    return (op == ALU_OP_MUL) || (op == ALU_OP_DIV);
  endfunction

endpackage

// File: rtl/multdiv_issue_ctrl_if.sv
// Handshake between the pipeline/multdiv unit and the issue controller.
// master = controller side, slave = pipeline and unit side.
interface multdiv_issue_ctrl_if #(parameter int COUNT_W = 6);

  logic               x_is_mul;
  logic               x_is_div;
  logic               flush;
  logic               multdiv_ready;
  logic               multdiv_exception;
  logic               start_mul;
  logic               start_div;
  logic               pc_we;
  logic               fd_we;
  logic               dx_we;
  logic               xm_bubble;
  logic               result_valid;
  logic               result_exc;
  logic               busy;
  logic [COUNT_W-1:0] md_count;
  logic               abort;

  modport master (
    input  x_is_mul, x_is_div, flush, multdiv_ready, multdiv_exception,
    output start_mul, start_div, pc_we, fd_we, dx_we, xm_bubble,
           result_valid, result_exc, busy, md_count, abort
  );

  modport slave (
    output x_is_mul, x_is_div, flush, multdiv_ready, multdiv_exception,
    input  start_mul, start_div, pc_we, fd_we, dx_we, xm_bubble,
           result_valid, result_exc, busy, md_count, abort
  );

endinterface

// File: rtl/multdiv_issue_ctrl_busy_counter.sv
// Saturating busy-cycle counter with synchronous clear and a terminal-count
// flag that fires when the count reaches TERM-1.
module md_busy_counter #(
  parameter int COUNT_W = 6,
  parameter int TERM    = 40
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               clear,
  input  logic               enable,
  output logic [COUNT_W-1:0] count,
  output logic               at_term
);

  always_ff @(posedge clock) begin
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != '1)) begin
      count <= count + COUNT_W'(1);
    end
  end

  assign at_term = (count == COUNT_W'(TERM - 1));

endmodule

// File: rtl/multdiv_issue_ctrl.sv
// Issue controller for the multi-cycle mul/div unit: starts it, stalls the
// front of the pipe while it runs. Watchdog abort enabled by MULTDIV_TIMEOUT_EN.
import multdiv_ctrl_pkg::*;

module multdiv_issue_ctrl #(
  parameter int COUNT_W        = COUNT_W_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input logic                  clock,
  input logic                  reset,
  multdiv_issue_ctrl_if.master bus
);

  logic               state;
  logic               state_nxt;
  logic               op_req;
  logic               cnt_clear;
  logic               cnt_en;
  logic [COUNT_W-1:0] count;
  logic               at_term;
  logic               timeout_hit;
  logic               start_mul_c;
  logic               start_div_c;
  logic               rv_c;
  logic               rx_c;
  logic               abort_c;
  pipe_ctrl_t         pipe;

  md_busy_counter #(
    .COUNT_W (COUNT_W),
    .TERM    (TIMEOUT_CYCLES)
  ) u_busy_counter (
    .clock   (clock),
    .reset   (reset),
    .clear   (cnt_clear),
    .enable  (cnt_en),
    .count   (count),
    .at_term (at_term)
  );

`ifdef MULTDIV_TIMEOUT_EN
  assign timeout_hit = at_term;
`else
  logic unused_at_term;
  assign unused_at_term = at_term;
  assign timeout_hit    = 1'b0;
`endif

  assign op_req = bus.x_is_mul | bus.x_is_div;

  // Priority in BUSY: flush beats ready, ready beats the watchdog.
  always_comb begin
    state_nxt   = state;
    pipe        = PIPE_RUN;
    start_mul_c = 1'b0;
    start_div_c = 1'b0;
    rv_c        = 1'b0;
    rx_c        = 1'b0;
    abort_c     = 1'b0;
    cnt_clear   = 1'b0;
    cnt_en      = 1'b0;
    if (state == S_IDLE) begin
      if (op_req && !bus.flush) begin
        start_mul_c = bus.x_is_mul;
        start_div_c = !bus.x_is_mul;
        pipe        = PIPE_HOLD;
        cnt_clear   = 1'b1;
        state_nxt   = S_BUSY;
      end
    end else begin
      if (bus.flush) begin
        state_nxt = S_IDLE;
      end else if (bus.multdiv_ready) begin
        rv_c      = 1'b1;
        rx_c      = bus.multdiv_exception;
        state_nxt = S_IDLE;
      end else if (timeout_hit) begin
        abort_c   = 1'b1;
        rv_c      = 1'b1;
        rx_c      = 1'b1;
        state_nxt = S_IDLE;
      end else begin
        pipe   = PIPE_HOLD;
        cnt_en = 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // While reset is low every output is forced to its quiescent value.
  assign bus.start_mul    = reset & start_mul_c;
  assign bus.start_div    = reset & start_div_c;
  assign bus.pc_we        = !reset | pipe.pc_we;
  assign bus.fd_we        = !reset | pipe.fd_we;
  assign bus.dx_we        = !reset | pipe.dx_we;
  assign bus.xm_bubble    = reset & pipe.xm_bubble;
  assign bus.result_valid = reset & rv_c;
  assign bus.result_exc   = reset & rx_c;
  assign bus.abort        = reset & abort_c;
  assign bus.busy         = reset & (state == S_BUSY);
  assign bus.md_count     = reset ? count : '0;

endmodule

// File: tb/tb_multdiv_issue_ctrl.sv
// Self-checking bench for multdiv_issue_ctrl: cycle table plus long sequences,
// expectations queued at drive time. Watchdog checks follow MULTDIV_TIMEOUT_EN.
module tb_multdiv_issue_ctrl;

  localparam int CW      = 6;
  localparam int TIMEOUT = 40;

  typedef struct packed {
    logic rst;
    logic mul;
    logic div;
    logic flush;
    logic rdy;
    logic exc;
  } in_t;

  typedef struct packed {
    logic          sm;
    logic          sd;
    logic          we;
    logic          bub;
    logic          rv;
    logic          rx;
    logic          busy;
    logic          abort;
    logic [CW-1:0] cnt;
    logic          chk_cnt;
  } exp_t;

  typedef struct packed {
    in_t  in;
    exp_t exp;
  } vec_t;

  logic clock;
  logic reset;
  int   n_vectors;
  int   n_miscompares;
  int   n_starts;
  exp_t sb[$];
  vec_t tbl[23];

  multdiv_issue_ctrl_if #(.COUNT_W(CW)) md_if();

  multdiv_issue_ctrl #(
    .COUNT_W        (CW),
    .TIMEOUT_CYCLES (TIMEOUT)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (md_if)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic in_t mk_in(logic rst, logic mul, logic div, logic flush, logic rdy, logic exc);
    return '{rst: rst, mul: mul, div: div, flush: flush, rdy: rdy, exc: exc};
  endfunction

  function automatic exp_t mk_exp(logic sm, logic sd, logic we, logic bub, logic rv, logic rx,
                                  logic busy, logic abort, int cnt, logic chk_cnt);
    return '{sm: sm, sd: sd, we: we, bub: bub, rv: rv, rx: rx, busy: busy, abort: abort,
             cnt: CW'(cnt), chk_cnt: chk_cnt};
  endfunction

  function automatic exp_t idle_exp();
    return mk_exp(0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
  endfunction

  function automatic int sat(int v);
    return (v > (1 << CW) - 1) ? (1 << CW) - 1 : v;
  endfunction

  task automatic cmp(input string tag, input string field, input int act, input int exp);
    if (act != exp) begin
      n_miscompares++;
      $display("[TB] FAIL %s %s: got %0d expected %0d", tag, field, act, exp);
    end
  endtask

  task automatic checkOutput(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      n_miscompares++;
      $display("[TB] FAIL %s scoreboard: got empty queue expected an entry", tag);
      return;
    end
    e = sb.pop_front();
    n_vectors++;
    n_starts += int'(md_if.start_mul) + int'(md_if.start_div);
    cmp(tag, "start_mul",    md_if.start_mul,    e.sm);
    cmp(tag, "start_div",    md_if.start_div,    e.sd);
    cmp(tag, "pc_we",        md_if.pc_we,        e.we);
    cmp(tag, "fd_we",        md_if.fd_we,        e.we);
    cmp(tag, "dx_we",        md_if.dx_we,        e.we);
    cmp(tag, "xm_bubble",    md_if.xm_bubble,    e.bub);
    cmp(tag, "result_valid", md_if.result_valid, e.rv);
    cmp(tag, "result_exc",   md_if.result_exc,   e.rx);
    cmp(tag, "busy",         md_if.busy,         e.busy);
    cmp(tag, "abort",        md_if.abort,        e.abort);
    if (e.chk_cnt) cmp(tag, "md_count", int'(md_if.md_count), int'(e.cnt));
  endtask

  task automatic applyStimulus(input in_t i, input exp_t e, input string tag);
    reset                   = i.rst;
    md_if.x_is_mul          = i.mul;
    md_if.x_is_div          = i.div;
    md_if.flush             = i.flush;
    md_if.multdiv_ready     = i.rdy;
    md_if.multdiv_exception = i.exc;
    if (i.rst && i.mul && i.div)
      $display("[TB] note %s: mul and div both decoded, expecting mul to win", tag);
    sb.push_back(e);
    @(negedge clock);
    checkOutput(tag);
    @(posedge clock);
    #1;
  endtask

  // One operation: start, lat-1 stalled cycles, then the release cycle.
  task automatic run_op(input logic is_div, input int lat, input logic exc, input string tag);
    applyStimulus(mk_in(1, !is_div, is_div, 0, 0, 0),
                  mk_exp(!is_div, is_div, 0, 1, 0, 0, 0, 0, 0, 0), {tag, ".start"});
    for (int k = 1; k < lat; k++)
      applyStimulus(mk_in(1, !is_div, is_div, 0, 0, 0),
                    mk_exp(0, 0, 0, 1, 0, 0, 1, 0, sat(k - 1), 1), {tag, ".busy"});
    applyStimulus(mk_in(1, !is_div, is_div, 0, 1, exc),
                  mk_exp(0, 0, 1, 0, 1, exc, 1, 0, sat(lat - 1), 1), {tag, ".release"});
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL global_timeout: got no completion expected $finish");
    $fatal(1, "[TB] bench did not complete");
  end

  initial begin
    n_vectors     = 0;
    n_miscompares = 0;
    n_starts      = 0;

    // rst mul div flush rdy exc | sm sd we bub rv rx busy abort cnt chk
    tbl[0]  = '{mk_in(0,1,0,0,1,0), mk_exp(0,0,1,0,0,0,0,0,0,1)};
    tbl[1]  = '{mk_in(0,1,0,0,1,0), mk_exp(0,0,1,0,0,0,0,0,0,1)};
    tbl[2]  = '{mk_in(0,1,0,0,1,0), mk_exp(0,0,1,0,0,0,0,0,0,1)};
    tbl[3]  = '{mk_in(1,0,0,0,1,1), mk_exp(0,0,1,0,0,0,0,0,0,1)};
    tbl[4]  = '{mk_in(1,1,0,1,0,0), mk_exp(0,0,1,0,0,0,0,0,0,1)};
    tbl[5]  = '{mk_in(1,0,1,0,1,0), mk_exp(0,1,0,1,0,0,0,0,0,1)};
    tbl[6]  = '{mk_in(1,0,1,0,0,0), mk_exp(0,0,0,1,0,0,1,0,0,1)};
    tbl[7]  = '{mk_in(1,0,1,0,0,0), mk_exp(0,0,0,1,0,0,1,0,1,1)};
    tbl[8]  = '{mk_in(1,0,1,0,1,1), mk_exp(0,0,1,0,1,1,1,0,2,1)};
    tbl[9]  = '{mk_in(1,0,0,0,0,0), mk_exp(0,0,1,0,0,0,0,0,0,0)};
    tbl[10] = '{mk_in(1,1,1,0,0,0), mk_exp(1,0,0,1,0,0,0,0,0,0)};
    tbl[11] = '{mk_in(1,1,1,0,0,0), mk_exp(0,0,0,1,0,0,1,0,0,1)};
    tbl[12] = '{mk_in(1,1,1,0,0,0), mk_exp(0,0,0,1,0,0,1,0,1,1)};
    tbl[13] = '{mk_in(1,1,1,0,0,0), mk_exp(0,0,0,1,0,0,1,0,2,1)};
    tbl[14] = '{mk_in(1,1,1,0,0,0), mk_exp(0,0,0,1,0,0,1,0,3,1)};
    tbl[15] = '{mk_in(1,1,1,0,0,0), mk_exp(0,0,0,1,0,0,1,0,4,1)};
    tbl[16] = '{mk_in(1,1,1,1,1,0), mk_exp(0,0,1,0,0,0,1,0,5,1)};
    tbl[17] = '{mk_in(1,0,0,0,1,0), mk_exp(0,0,1,0,0,0,0,0,0,0)};
    tbl[18] = '{mk_in(1,0,0,0,0,0), mk_exp(0,0,1,0,0,0,0,0,0,0)};
    tbl[19] = '{mk_in(1,1,0,0,0,0), mk_exp(1,0,0,1,0,0,0,0,0,0)};
    tbl[20] = '{mk_in(1,1,0,0,0,0), mk_exp(0,0,0,1,0,0,1,0,0,1)};
    tbl[21] = '{mk_in(0,1,0,0,0,0), mk_exp(0,0,1,0,0,0,0,0,0,1)};
    tbl[22] = '{mk_in(1,0,0,0,1,1), mk_exp(0,0,1,0,0,0,0,0,0,1)};

    reset                   = 1'b0;
    md_if.x_is_mul          = 1'b0;
    md_if.x_is_div          = 1'b0;
    md_if.flush             = 1'b0;
    md_if.multdiv_ready     = 1'b0;
    md_if.multdiv_exception = 1'b0;
    @(posedge clock);
    #1;

    $display("[TB] cycle table");
    for (int i = 0; i < 23; i++)
      applyStimulus(tbl[i].in, tbl[i].exp, $sformatf("tbl[%0d]", i));

    $display("[TB] basic mul, 32-cycle latency");
    run_op(0, 32, 0, "mul32");
    applyStimulus(mk_in(1, 0, 0, 0, 0, 0), idle_exp(), "mul32.after");

    $display("[TB] back-to-back mul then div");
    n_starts = 0;
    run_op(0, 17, 0, "b2b.mul");
    run_op(1, 17, 0, "b2b.div");
    applyStimulus(mk_in(1, 0, 0, 0, 0, 0), idle_exp(), "b2b.after");
    n_vectors++;
    cmp("b2b", "start_pulses", n_starts, 2);

    $display("[TB] flush during busy");
    n_starts = 0;
    applyStimulus(mk_in(1, 1, 0, 0, 0, 0), mk_exp(1, 0, 0, 1, 0, 0, 0, 0, 0, 0), "flush.start");
    for (int k = 1; k <= 5; k++)
      applyStimulus(mk_in(1, 1, 0, 0, 0, 0), mk_exp(0, 0, 0, 1, 0, 0, 1, 0, k - 1, 1), "flush.busy");
    applyStimulus(mk_in(1, 1, 0, 1, 0, 0), mk_exp(0, 0, 1, 0, 0, 0, 1, 0, 5, 1), "flush.hit");
    for (int k = 1; k <= 10; k++)
      applyStimulus(mk_in(1, 0, 0, 0, (k == 10), 0), idle_exp(), "flush.late");
    n_vectors++;
    cmp("flush", "start_pulses", n_starts, 1);

    $display("[TB] divide by zero");
    run_op(1, 5, 1, "dbz");
    applyStimulus(mk_in(1, 0, 0, 0, 0, 0), idle_exp(), "dbz.after");

    $display("[TB] unit never ready");
    applyStimulus(mk_in(1, 1, 0, 0, 0, 0), mk_exp(1, 0, 0, 1, 0, 0, 0, 0, 0, 0), "wd.start");
`ifdef MULTDIV_TIMEOUT_EN
    for (int k = 1; k < TIMEOUT; k++)
      applyStimulus(mk_in(1, 1, 0, 0, 0, 0), mk_exp(0, 0, 0, 1, 0, 0, 1, 0, k - 1, 1), "wd.busy");
    applyStimulus(mk_in(1, 1, 0, 0, 0, 0), mk_exp(0, 0, 1, 0, 1, 1, 1, 1, TIMEOUT - 1, 1), "wd.abort");
`else
    for (int k = 1; k <= 110; k++)
      applyStimulus(mk_in(1, 1, 0, 0, 0, 0), mk_exp(0, 0, 0, 1, 0, 0, 1, 0, sat(k - 1), 1), "wd.stall");
    applyStimulus(mk_in(1, 1, 0, 1, 0, 0), mk_exp(0, 0, 1, 0, 0, 0, 1, 0, sat(110), 1), "wd.flush");
`endif
    applyStimulus(mk_in(1, 0, 0, 0, 0, 0), idle_exp(), "wd.after");

    n_vectors++;
    cmp("end", "scoreboard_left", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

endmodule
